// File: rtl/hazard_pkg.sv
// Shared definitions for the IF/ID hazard controller and related pipeline helpers.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W_DEFAULT = 5;
  localparam int unsigned X0                 = 0;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_FLUSH    = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// Load-use comparator: the ID instruction reads the register a load in EX is about to write.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  uses_rs1_i,
  input  logic                  uses_rs2_i,
  input  logic                  mem_read_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  output logic                  lu_c_o
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hard-wired to zero, so a load targeting it never produces a dependency.
  assign rd_live = mem_read_i && (rd_i != REG_ADDR_W'(X0));
  assign rs1_hit = uses_rs1_i && (rs1_i == rd_i);
  assign rs2_hit = uses_rs2_i && (rs2_i == rd_i);
  assign lu_c_o  = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the IF/ID register, PC enable and ID/EX bubble.
// Optional HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W        = REG_ADDR_W_DEFAULT,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned CNT_W             = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pipe_hold,
  output logic [1:0]            hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_cycles
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] STALL_REL = CNT_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_REL = CNT_W'(FLUSH_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_c;

  hazard_lu_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu_detect (
    .rs1_i      (id_rs1),
    .rs2_i      (id_rs2),
    .uses_rs1_i (id_uses_rs1),
    .uses_rs2_i (id_uses_rs2),
    .mem_read_i (ex_mem_read),
    .rd_i       (ex_rd),
    .lu_c_o     (lu_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mealy next-state/output: mem_busy > branch > load-use > default.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;

    if (mem_busy) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      pipe_hold    = 1'b1;
    end else if (ex_branch_taken && (state_q != HZ_FLUSH)) begin
      // A taken branch also abandons any load-use stall in progress.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = HZ_FLUSH;
        cnt_d   = FLUSH_REL;
      end else begin
        state_d = HZ_RUN;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        HZ_LU_STALL: begin
          pc_enable    = 1'b0;
          if_id_enable = 1'b0;
          id_ex_bubble = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = HZ_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        HZ_FLUSH: begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
          if (cnt_q <= CNT_ONE) begin
            state_d = HZ_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          // HZ_RUN, and recovery from the unused encoding.
          state_d = HZ_RUN;
          cnt_d   = '0;
          if (lu_c) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            id_ex_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = HZ_LU_STALL;
              cnt_d   = STALL_REL;
            end
          end
        end
      endcase
    end

    if (reset) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  assign hz_state = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Saturating counters; reset keeps them at zero so reset cycles are never counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_enable && !mem_busy && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_cycles = flush_cnt_q;
`endif

endmodule
